mem_lsu: RTL and testbench
==========================

Name: mem_lsu

Overview:
- Memory-access stage of the 5-stage RISC-V pipeline, between the ex_mem register and the mem_wb register.
- Non-memory ops pass straight through to the mem_wb inputs (0 latency).
- Loads and stores run a request/acknowledge transaction on the data bus. The block raises a stall request until the bus acknowledges, then presents the formatted load result or the store completion for exactly one cycle.

Parameters:
- DATA_W, 32, register/bus data width; only 32 is supported.
- REG_ADDR_W, 5, register-file address width.
- ADDR_W, 32, data-bus byte address width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- ex_waddr  in  REG_ADDR_W  destination register from ex_mem
- ex_we  in  1  register write enable from ex_mem
- ex_wdata  in  DATA_W  ALU result from ex_mem
- ex_memop  in  4  memory op code (package enum)
- ex_maddr  in  ADDR_W  effective byte address
- ex_sdata  in  DATA_W  store data (rs2)
- mem_waddr  out  REG_ADDR_W  to mem_wb
- mem_we  out  1  to mem_wb
- mem_wdata  out  DATA_W  to mem_wb
- stall_req  out  1  freeze request to the stall controller
- bus_req  out  1  data-bus request
- bus_wr  out  1  1 = write
- bus_addr  out  ADDR_W  word-aligned address (bits [1:0] = 0)
- bus_sel  out  4  byte-lane enables
- bus_wdata  out  DATA_W  lane-replicated store data
- bus_ack  in  1  transaction complete; rdata valid this cycle
- bus_rdata  in  DATA_W  read data

Behaviour:
- Reset: all outputs 0; state returns to IDLE on the next clk edge. Reset mid-transaction drops bus_req at that edge, discards any late bus_ack and does not retry.
- Op codes: NONE, LB, LH, LW, LBU, LHU, SB, SH, SW.
- NONE: mem_* outputs equal ex_* inputs combinationally; stall_req = 0; bus idle.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - A memory op drives stall_req = 1 and mem_we = 0 combinationally.
  - Registers address, op, sel, wdata and destination.
  - Next state is BUSY.
- BUSY:
  - bus_req = 1; address, sel and wdata are held stable from registers.
  - stall_req = 1; mem_we = 0.
  - On bus_ack, latch the formatted rdata and go to RESP. Ack may arrive in the first BUSY cycle, giving a minimum 2 stall cycles.
- RESP:
  - bus_req = 0; stall_req = 0.
  - Loads: mem_we = registered we; mem_wdata = formatted load; mem_waddr = registered dest.
  - Stores: mem_we = 0.
  - Next state is IDLE unconditionally. The pipeline advances on this edge, so the same op is never reissued.
- Lanes: bus_sel is 0001<<a[1:0] for byte ops, 0011<<a[1:0] for half, 1111 for word. Store data is replicated: byte to all 4 lanes, half to both halves.
- Load format:
  - Select the lane by a[1:0].
  - LB/LH sign-extend; LBU/LHU zero-extend.
- Alignment: half at a[0] = 1 or word at a[1:0] ≠ 0 is misaligned. Without the feature, a misaligned access is performed with the low address bits forced aligned (a[0] cleared for half, a[1:0] cleared for word).
- ex_* changes while the FSM is not IDLE are ignored, because the stall controller holds ex_mem.

Optional Feature:
- Macro: MEM_MISALIGN_TRAP_EN.
- When defined:
  - Adds output misalign (1 bit).
  - A misaligned op in IDLE issues no bus request and goes directly to RESP.
  - In RESP: misalign = 1, mem_we = 0, stall_req = 0, 1 stall cycle.
- When undefined: port absent; forced-aligned behaviour as above.

Decomposition:
- Shared package/defines file holds:
  - memop enum and width.
  - FSM state encoding.
  - RegBus / RegAddrBus widths.
- One natural sub-module: mem_lsu_fmt, combinational lane select, sign/zero extension and store replication, instantiated once.

Test Plan:
- NONE op, ex_waddr=5, ex_wdata=0x1234 -> same cycle mem_we=1, mem_wdata=0x1234, stall_req=0, bus_req=0.
- LW addr 0x100, ack on first BUSY cycle, rdata=0xDEADBEEF -> stall_req high 2 cycles, then RESP: mem_wdata=0xDEADBEEF, mem_we=1; bus_sel=1111.
- LB addr 0x103, rdata=0x80xxxxxx -> bus_sel=1000, mem_wdata=0xFFFFFF80. LBU same -> 0x00000080. LH addr 0x102, rdata=0x8001xxxx -> 0xFFFF8001.
- SB addr 0x101, sdata=0xAB, ack after 3 wait cycles -> bus_wr=1, bus_sel=0010, bus_wdata=0xABABABAB held stable all BUSY cycles, mem_we=0 in RESP.
- rst asserted during BUSY, bus_ack one cycle later -> next edge bus_req=0, IDLE, ack ignored, all outputs 0.
- With MEM_MISALIGN_TRAP_EN: LW addr 0x102 -> no bus_req, misalign=1 and mem_we=0 for one cycle.

Source files
------------

// File: rtl/mem_lsu_pkg.sv
// Shared types for the memory-access stage: memop encoding, FSM states,
// bus widths and small decode helpers.
package mem_lsu_pkg;

    localparam int unsigned RegBus     = 32;
    localparam int unsigned RegAddrBus = 5;
    localparam int unsigned AddrBus    = 32;
    localparam int unsigned MemopW     = 4;

    typedef enum logic [MemopW-1:0] {
        MEMOP_NONE = 4'd0,
        MEMOP_LB   = 4'd1,
        MEMOP_LH   = 4'd2,
        MEMOP_LW   = 4'd3,
        MEMOP_LBU  = 4'd4,
        MEMOP_LHU  = 4'd5,
        MEMOP_SB   = 4'd6,
        MEMOP_SH   = 4'd7,
        MEMOP_SW   = 4'd8
    } memop_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    function automatic logic memop_is_load(memop_e op);
        return op inside {MEMOP_LB, MEMOP_LH, MEMOP_LW, MEMOP_LBU, MEMOP_LHU};
    endfunction

    function automatic logic memop_is_store(memop_e op);
        return op inside {MEMOP_SB, MEMOP_SH, MEMOP_SW};
    endfunction

    function automatic logic memop_misaligned(memop_e op, logic [1:0] off);
        return (op inside {MEMOP_LH, MEMOP_LHU, MEMOP_SH} && off[0]) ||
               (op inside {MEMOP_LW, MEMOP_SW} && (off != 2'b00));
    endfunction

    // Byte offset actually used on the bus: low bits forced aligned to the access size.
    function automatic logic [1:0] memop_align_off(memop_e op, logic [1:0] off);
        if (op inside {MEMOP_LH, MEMOP_LHU, MEMOP_SH}) return {off[1], 1'b0};
        if (op inside {MEMOP_LW, MEMOP_SW})            return 2'b00;
        return off;
    endfunction

endpackage

// File: rtl/mem_lsu_fmt.sv
// Combinational lane logic: byte-lane enables, store-data replication and
// load lane select with sign/zero extension.
// Ports: op/off select the access; sdata -> wdata (replicated), rdata -> ldata.
module mem_lsu_fmt
    import mem_lsu_pkg::*;
(
    input  memop_e            op,
    input  logic [1:0]        off,
    input  logic [RegBus-1:0] sdata,
    input  logic [RegBus-1:0] rdata,
    output logic [3:0]        sel,
    output logic [RegBus-1:0] wdata,
    output logic [RegBus-1:0] ldata
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    // Lane extraction from the read word
    always_comb begin
        case (off)
            2'd0:    lane_b = rdata[7:0];
            2'd1:    lane_b = rdata[15:8];
            2'd2:    lane_b = rdata[23:16];
            default: lane_b = rdata[31:24];
        endcase
        lane_h = off[1] ? rdata[31:16] : rdata[15:0];
    end

    // Per-op lane enables and data formatting
    always_comb begin
        sel   = 4'b0000;
        wdata = '0;
        ldata = '0;
        case (op)
            MEMOP_LB:  begin sel = 4'b0001 << off; ldata = {{24{lane_b[7]}}, lane_b};  end
            MEMOP_LBU: begin sel = 4'b0001 << off; ldata = {24'b0, lane_b};            end
            MEMOP_LH:  begin sel = 4'b0011 << off; ldata = {{16{lane_h[15]}}, lane_h}; end
            MEMOP_LHU: begin sel = 4'b0011 << off; ldata = {16'b0, lane_h};            end
            MEMOP_LW:  begin sel = 4'b1111;        ldata = rdata;                      end
            MEMOP_SB:  begin sel = 4'b0001 << off; wdata = {4{sdata[7:0]}};            end
            MEMOP_SH:  begin sel = 4'b0011 << off; wdata = {2{sdata[15:0]}};           end
            MEMOP_SW:  begin sel = 4'b1111;        wdata = sdata;                      end
            default:   ;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// Memory-access pipeline stage. Non-memory ops pass through combinationally;
// loads/stores run a req/ack bus transaction while holding stall_req, then
// present the result (or store completion) for one cycle.
// Ports: clk/rst (sync, active-high); ex_* from ex_mem; mem_* to mem_wb;
// stall_req to the stall controller; bus_* data-bus master interface.
// Optional macro MEM_MISALIGN_TRAP_EN adds output misalign and skips the bus
// for misaligned accesses; otherwise misaligned accesses are forced aligned.
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int unsigned DATA_W     = RegBus,
    parameter int unsigned REG_ADDR_W = RegAddrBus,
    parameter int unsigned ADDR_W     = AddrBus
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] ex_waddr,
    input  logic                  ex_we,
    input  logic [DATA_W-1:0]     ex_wdata,
    input  logic [MemopW-1:0]     ex_memop,
    input  logic [ADDR_W-1:0]     ex_maddr,
    input  logic [DATA_W-1:0]     ex_sdata,
    output logic [REG_ADDR_W-1:0] mem_waddr,
    output logic                  mem_we,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic                  stall_req,
    output logic                  bus_req,
    output logic                  bus_wr,
    output logic [ADDR_W-1:0]     bus_addr,
    output logic [3:0]            bus_sel,
    output logic [DATA_W-1:0]     bus_wdata,
    input  logic                  bus_ack,
    input  logic [DATA_W-1:0]     bus_rdata
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    output logic                  misalign
`endif
);

    state_e                state_q, state_d;
    memop_e                op_q, op_d;
    logic [1:0]            off_q, off_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [3:0]            sel_q, sel_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic [DATA_W-1:0]     rdata_q, rdata_d;
    logic [REG_ADDR_W-1:0] waddr_q, waddr_d;
    logic                  we_q, we_d;
`ifdef MEM_MISALIGN_TRAP_EN
    logic                  mis_q, mis_d;
    logic                  ex_mis;
`endif

    memop_e      ex_op;
    logic        ex_is_mem;
    logic [1:0]  ex_off;
    memop_e      fmt_op;
    logic [1:0]  fmt_off;
    logic [3:0]  fmt_sel;
    logic [DATA_W-1:0] fmt_wdata, fmt_ldata;

    assign ex_op     = memop_e'(ex_memop);
    assign ex_is_mem = memop_is_load(ex_op) || memop_is_store(ex_op);
    assign ex_off    = memop_align_off(ex_op, ex_maddr[1:0]);
`ifdef MEM_MISALIGN_TRAP_EN
    assign ex_mis    = memop_misaligned(ex_op, ex_maddr[1:0]);
`endif

    // Single formatter: request side uses ex_* in IDLE, load side uses the held op in BUSY
    assign fmt_op  = (state_q == ST_IDLE) ? ex_op  : op_q;
    assign fmt_off = (state_q == ST_IDLE) ? ex_off : off_q;

    mem_lsu_fmt u_fmt (
        .op    (fmt_op),
        .off   (fmt_off),
        .sdata (ex_sdata),
        .rdata (bus_rdata),
        .sel   (fmt_sel),
        .wdata (fmt_wdata),
        .ldata (fmt_ldata)
    );

    // Next-state and capture logic
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        off_d   = off_q;
        addr_d  = addr_q;
        sel_d   = sel_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        waddr_d = waddr_q;
        we_d    = we_q;
`ifdef MEM_MISALIGN_TRAP_EN
        mis_d   = mis_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (ex_is_mem) begin
                    op_d    = ex_op;
                    off_d   = ex_off;
                    addr_d  = {ex_maddr[ADDR_W-1:2], 2'b00};
                    sel_d   = fmt_sel;
                    wdata_d = fmt_wdata;
                    waddr_d = ex_waddr;
                    we_d    = ex_we;
`ifdef MEM_MISALIGN_TRAP_EN
                    mis_d   = ex_mis;
                    state_d = ex_mis ? ST_RESP : ST_BUSY;
`else
                    state_d = ST_BUSY;
`endif
                end
            end
            ST_BUSY: begin
                if (bus_ack) begin
                    rdata_d = fmt_ldata;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_q    <= MEMOP_NONE;
            off_q   <= 2'b00;
            addr_q  <= '0;
            sel_q   <= 4'b0000;
            wdata_q <= '0;
            rdata_q <= '0;
            waddr_q <= '0;
            we_q    <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
            mis_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            off_q   <= off_d;
            addr_q  <= addr_d;
            sel_q   <= sel_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            waddr_q <= waddr_d;
            we_q    <= we_d;
`ifdef MEM_MISALIGN_TRAP_EN
            mis_q   <= mis_d;
`endif
        end
    end

    // Outputs: pass-through in IDLE, held registers otherwise; bus driven only in BUSY
    always_comb begin
        mem_waddr = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        stall_req = 1'b0;
        bus_req   = 1'b0;
        bus_wr    = 1'b0;
        bus_addr  = '0;
        bus_sel   = 4'b0000;
        bus_wdata = '0;
`ifdef MEM_MISALIGN_TRAP_EN
        misalign  = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                mem_waddr = ex_waddr;
                mem_wdata = ex_wdata;
                mem_we    = ex_is_mem ? 1'b0 : ex_we;
                stall_req = ex_is_mem;
            end
            ST_BUSY: begin
                mem_waddr = waddr_q;
                stall_req = 1'b1;
                bus_req   = 1'b1;
                bus_wr    = memop_is_store(op_q);
                bus_addr  = addr_q;
                bus_sel   = sel_q;
                bus_wdata = wdata_q;
            end
            ST_RESP: begin
                mem_waddr = waddr_q;
                mem_wdata = rdata_q;
`ifdef MEM_MISALIGN_TRAP_EN
                mem_we    = we_q && memop_is_load(op_q) && !mis_q;
                misalign  = mis_q;
`else
                mem_we    = we_q && memop_is_load(op_q);
`endif
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_lsu.sv
// Testbench for mem_lsu: scenario tasks with a scoreboard queue of expected
// transaction results, compared when the stage presents its response cycle.
module tb_mem_lsu;
    import mem_lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  ex_waddr;
    logic        ex_we;
    logic [31:0] ex_wdata;
    logic [3:0]  ex_memop;
    logic [31:0] ex_maddr;
    logic [31:0] ex_sdata;
    logic [4:0]  mem_waddr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic        stall_req;
    logic        bus_req;
    logic        bus_wr;
    logic [31:0] bus_addr;
    logic [3:0]  bus_sel;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;
`ifdef MEM_MISALIGN_TRAP_EN
    logic        misalign;
`endif

    always #5 clk = ~clk;

    mem_lsu dut (
        .clk       (clk),
        .rst       (rst),
        .ex_waddr  (ex_waddr),
        .ex_we     (ex_we),
        .ex_wdata  (ex_wdata),
        .ex_memop  (ex_memop),
        .ex_maddr  (ex_maddr),
        .ex_sdata  (ex_sdata),
        .mem_waddr (mem_waddr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .stall_req (stall_req),
        .bus_req   (bus_req),
        .bus_wr    (bus_wr),
        .bus_addr  (bus_addr),
        .bus_sel   (bus_sel),
        .bus_wdata (bus_wdata),
        .bus_ack   (bus_ack),
        .bus_rdata (bus_rdata)
`ifdef MEM_MISALIGN_TRAP_EN
        ,
        .misalign  (misalign)
`endif
    );

    typedef struct {
        logic [31:0] wdata;
        logic        we;
        logic [4:0]  waddr;
        logic        bus_seen;
        logic        wr;
        logic [31:0] baddr;
        logic [3:0]  sel;
        logic [31:0] bwdata;
        int          stalls;
        logic        mis;
    } txn_t;

    int   checks = 0;
    int   errors = 0;
    txn_t sb_q[$];
    txn_t obs;
    logic obs_stable;
    logic obs_timeout;

    // Independent expected-load model
    function automatic logic [31:0] model_load(memop_e op, logic [31:0] a, logic [31:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        case (a[1:0])
            2'd0: b = d[7:0];
            2'd1: b = d[15:8];
            2'd2: b = d[23:16];
            default: b = d[31:24];
        endcase
        h = a[1] ? d[31:16] : d[15:0];
        case (op)
            MEMOP_LB:  return {{24{b[7]}}, b};
            MEMOP_LBU: return {24'h0, b};
            MEMOP_LH:  return {{16{h[15]}}, h};
            MEMOP_LHU: return {16'h0, h};
            default:   return d;
        endcase
    endfunction

    // Issues one op at posedge+1 and follows it to the response cycle; records observations only
    task automatic run_op(input memop_e op, input logic [31:0] addr, input logic [31:0] sdata,
                          input logic [31:0] rdata, input logic [4:0] waddr, input int waits);
        int  busy = 0;
        logic done = 1'b0;
        obs.wdata = '0; obs.we = 1'b0; obs.waddr = '0; obs.bus_seen = 1'b0; obs.wr = 1'b0;
        obs.baddr = '0; obs.sel = '0; obs.bwdata = '0; obs.stalls = 0; obs.mis = 1'b0;
        obs_stable = 1'b1;
        ex_memop = 4'(op); ex_maddr = addr; ex_sdata = sdata; ex_waddr = waddr;
        ex_we = memop_is_load(op); ex_wdata = 32'h5555_AAAA;
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            #1;
            if (!stall_req) begin
                obs.we = mem_we; obs.wdata = mem_wdata; obs.waddr = mem_waddr;
`ifdef MEM_MISALIGN_TRAP_EN
                obs.mis = misalign;
`endif
                done = 1'b1;
                ex_memop = 4'(MEMOP_NONE); ex_we = 1'b0;
            end else begin
                obs.stalls++;
                if (bus_req) begin
                    if (!obs.bus_seen) begin
                        obs.wr = bus_wr; obs.baddr = bus_addr; obs.sel = bus_sel; obs.bwdata = bus_wdata;
                    end else if ({obs.wr, obs.baddr, obs.sel, obs.bwdata} !== {bus_wr, bus_addr, bus_sel, bus_wdata}) begin
                        obs_stable = 1'b0;
                    end
                    obs.bus_seen = 1'b1;
                    if (busy == waits) begin bus_ack = 1'b1; bus_rdata = rdata; end
                    busy++;
                end
            end
            @(posedge clk); #1;
            bus_ack = 1'b0; bus_rdata = $urandom;
        end
        obs_timeout = !done;
    endtask

    task automatic test_reset();
        rst = 1'b1; bus_ack = 1'b0; bus_rdata = '0;
        ex_memop = 4'(MEMOP_NONE); ex_we = 1'b0; ex_waddr = '0; ex_wdata = '0; ex_maddr = '0; ex_sdata = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({mem_we, mem_wdata, mem_waddr, stall_req, bus_req, bus_wr, bus_addr, bus_sel, bus_wdata} !== '0) begin
            errors++; $display("FAIL reset_outputs got we=%b st=%b req=%b sel=%b want all 0", mem_we, stall_req, bus_req, bus_sel);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_none();
        ex_memop = 4'(MEMOP_NONE); ex_waddr = 5'd5; ex_we = 1'b1; ex_wdata = 32'h1234; ex_maddr = 32'h100;
        #1;
        checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL none_we got %b want 1", mem_we); end
        checks++; if (mem_wdata !== 32'h1234) begin errors++; $display("FAIL none_wdata got %h want 00001234", mem_wdata); end
        checks++; if (mem_waddr !== 5'd5) begin errors++; $display("FAIL none_waddr got %0d want 5", mem_waddr); end
        checks++; if ({stall_req, bus_req} !== 2'b00) begin errors++; $display("FAIL none_stall_bus got %b want 00", {stall_req, bus_req}); end
        @(posedge clk); #1;
        ex_we = 1'b0;
    endtask

    typedef struct {
        memop_e      op;
        logic [31:0] addr;
        logic [31:0] rdata;
        logic [31:0] exp;
        logic [3:0]  sel;
        int          waits;
    } ld_t;

    task automatic test_loads();
        ld_t tbl[6];
        txn_t e;
        tbl = '{'{MEMOP_LW,  32'h100, 32'hDEADBEEF, 32'hDEADBEEF, 4'b1111, 0},
                '{MEMOP_LB,  32'h103, 32'h80123456, 32'hFFFFFF80, 4'b1000, 0},
                '{MEMOP_LBU, 32'h103, 32'h80123456, 32'h00000080, 4'b1000, 1},
                '{MEMOP_LH,  32'h102, 32'h80015678, 32'hFFFF8001, 4'b1100, 0},
                '{MEMOP_LHU, 32'h100, 32'h1234F00D, 32'h0000F00D, 4'b0011, 2},
                '{MEMOP_LB,  32'h101, 32'h00007F00, 32'h0000007F, 4'b0010, 1}};
        foreach (tbl[i]) begin
            e.wdata = tbl[i].exp; e.we = 1'b1; e.waddr = 5'(i + 1); e.sel = tbl[i].sel;
            e.baddr = {tbl[i].addr[31:2], 2'b00}; e.stalls = 2 + tbl[i].waits;
            sb_q.push_back(e);
            run_op(tbl[i].op, tbl[i].addr, 32'h0, tbl[i].rdata, 5'(i + 1), tbl[i].waits);
            e = sb_q.pop_front();
            checks++; if (obs_timeout) begin errors++; $display("FAIL load%0d_timeout got no response want response", i); end
            checks++; if (obs.wdata !== e.wdata) begin errors++; $display("FAIL load%0d_wdata got %h want %h", i, obs.wdata, e.wdata); end
            checks++; if ({obs.we, obs.waddr} !== {e.we, e.waddr}) begin errors++; $display("FAIL load%0d_we_waddr got %b/%0d want %b/%0d", i, obs.we, obs.waddr, e.we, e.waddr); end
            checks++; if ({obs.sel, obs.baddr, obs.wr} !== {e.sel, e.baddr, 1'b0}) begin errors++; $display("FAIL load%0d_bus got sel=%b addr=%h wr=%b want sel=%b addr=%h wr=0", i, obs.sel, obs.baddr, obs.wr, e.sel, e.baddr); end
            checks++; if (obs.stalls != e.stalls) begin errors++; $display("FAIL load%0d_stalls got %0d want %0d", i, obs.stalls, e.stalls); end
        end
    endtask

    task automatic test_stores();
        txn_t e;
        memop_e      ops[3]   = '{MEMOP_SB, MEMOP_SH, MEMOP_SW};
        logic [31:0] addrs[3] = '{32'h101, 32'h102, 32'h204};
        logic [31:0] sd[3]    = '{32'h000000AB, 32'h1234CAFE, 32'h0BADF00D};
        logic [31:0] bw[3]    = '{32'hABABABAB, 32'hCAFECAFE, 32'h0BADF00D};
        logic [3:0]  sels[3]  = '{4'b0010, 4'b1100, 4'b1111};
        int          wt[3]    = '{3, 0, 1};
        for (int i = 0; i < 3; i++) begin
            e.bwdata = bw[i]; e.sel = sels[i]; e.baddr = {addrs[i][31:2], 2'b00}; e.stalls = 2 + wt[i];
            sb_q.push_back(e);
            run_op(ops[i], addrs[i], sd[i], 32'hFFFFFFFF, 5'd0, wt[i]);
            e = sb_q.pop_front();
            checks++; if (obs_timeout) begin errors++; $display("FAIL store%0d_timeout got no response want response", i); end
            checks++; if (obs.wr !== 1'b1) begin errors++; $display("FAIL store%0d_wr got %b want 1", i, obs.wr); end
            checks++; if ({obs.sel, obs.baddr} !== {e.sel, e.baddr}) begin errors++; $display("FAIL store%0d_sel_addr got %b/%h want %b/%h", i, obs.sel, obs.baddr, e.sel, e.baddr); end
            checks++; if (obs.bwdata !== e.bwdata) begin errors++; $display("FAIL store%0d_wdata got %h want %h", i, obs.bwdata, e.bwdata); end
            checks++; if (!obs_stable) begin errors++; $display("FAIL store%0d_stable got changing bus want stable", i); end
            checks++; if (obs.we !== 1'b0) begin errors++; $display("FAIL store%0d_mem_we got %b want 0", i, obs.we); end
            checks++; if (obs.stalls != e.stalls) begin errors++; $display("FAIL store%0d_stalls got %0d want %0d", i, obs.stalls, e.stalls); end
        end
    endtask

    task automatic test_back_to_back();
        txn_t e;
        memop_e lops[5] = '{MEMOP_LB, MEMOP_LH, MEMOP_LW, MEMOP_LBU, MEMOP_LHU};
        for (int i = 0; i < 10; i++) begin
            memop_e      op = lops[$urandom_range(0, 4)];
            logic [31:0] a  = $urandom & 32'h0000FFFC;
            logic [31:0] d  = $urandom;
            int          w  = $urandom_range(0, 2);
            if (op inside {MEMOP_LB, MEMOP_LBU}) a[1:0] = 2'($urandom_range(0, 3));
            if (op inside {MEMOP_LH, MEMOP_LHU}) a[1]   = 1'($urandom_range(0, 1));
            e.wdata = model_load(op, a, d); e.we = 1'b1; e.waddr = 5'(i + 7);
            sb_q.push_back(e);
            run_op(op, a, 32'h0, d, 5'(i + 7), w);
            e = sb_q.pop_front();
            checks++;
            if (obs_timeout || obs.wdata !== e.wdata || obs.we !== 1'b1 || obs.waddr !== e.waddr) begin
                errors++; $display("FAIL b2b%0d op=%0d addr=%h got %h/%b/%0d want %h/1/%0d", i, op, a, obs.wdata, obs.we, obs.waddr, e.wdata, e.waddr);
            end
        end
    endtask

    task automatic test_reset_mid();
        ex_memop = 4'(MEMOP_LW); ex_maddr = 32'h200; ex_waddr = 5'd9; ex_we = 1'b1;
        @(posedge clk); #1;
        checks++; if (bus_req !== 1'b1) begin errors++; $display("FAIL rstmid_busy got bus_req=%b want 1", bus_req); end
        rst = 1'b1;
        ex_memop = 4'(MEMOP_NONE); ex_we = 1'b0; ex_waddr = '0; ex_wdata = '0; ex_maddr = '0; ex_sdata = '0;
        @(posedge clk); #1;
        rst = 1'b0; bus_ack = 1'b1; bus_rdata = 32'hCAFEBABE;
        #1;
        checks++;
        if ({mem_we, mem_wdata, mem_waddr, stall_req, bus_req, bus_wr, bus_addr, bus_sel, bus_wdata} !== '0) begin
            errors++; $display("FAIL rstmid_dropped got req=%b st=%b we=%b want all 0", bus_req, stall_req, mem_we);
        end
        @(posedge clk); #1;
        bus_ack = 1'b0;
        #1;
        checks++;
        if ({mem_we, mem_wdata, stall_req, bus_req} !== '0) begin
            errors++; $display("FAIL rstmid_late_ack got we=%b wdata=%h req=%b want 0", mem_we, mem_wdata, bus_req);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_misalign();
        run_op(MEMOP_LW, 32'h102, 32'h0, 32'h11223344, 5'd3, 0);
        checks++; if (obs_timeout) begin errors++; $display("FAIL mis_timeout got no response want response"); end
`ifdef MEM_MISALIGN_TRAP_EN
        checks++; if (obs.bus_seen !== 1'b0) begin errors++; $display("FAIL mis_bus got bus_req seen want none"); end
        checks++; if ({obs.mis, obs.we} !== 2'b10) begin errors++; $display("FAIL mis_flag got misalign=%b we=%b want 1/0", obs.mis, obs.we); end
        checks++; if (obs.stalls != 1) begin errors++; $display("FAIL mis_stalls got %0d want 1", obs.stalls); end
        #1;
        checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL mis_oneshot got %b want 0", misalign); end
`else
        checks++; if ({obs.baddr, obs.sel} !== {32'h100, 4'b1111}) begin errors++; $display("FAIL mis_lw_bus got %h/%b want 00000100/1111", obs.baddr, obs.sel); end
        checks++; if (obs.wdata !== 32'h11223344) begin errors++; $display("FAIL mis_lw_wdata got %h want 11223344", obs.wdata); end
        run_op(MEMOP_LH, 32'h103, 32'h0, 32'hBEEF1234, 5'd4, 1);
        checks++; if ({obs.sel, obs.wdata} !== {4'b1100, 32'hFFFFBEEF}) begin errors++; $display("FAIL mis_lh got %b/%h want 1100/ffffbeef", obs.sel, obs.wdata); end
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_none();
        test_loads();
        test_stores();
        test_back_to_back();
        test_misalign();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
